// File: rtl/outword_stream_bridge_pkg.sv
// rtl/outword_stream_bridge_pkg.sv - shared types and helpers for the MMIO output/input stream bridges
package outword_stream_bridge_pkg;

  localparam int OUTWORD_W = 32;

  typedef struct packed {
    logic [OUTWORD_W-1:0] word2;
    logic [OUTWORD_W-1:0] word1;
  } stream_entry_t;

  // Pointer width carries one extra wrap bit so full and empty are distinguishable.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/outword_stream_bridge_if.sv
// rtl/outword_stream_bridge_if.sv - valid/ready stream carrying {OutWord2, OutWord1} entries
interface outword_stream_bridge_if #(
  parameter int W = 64
) ();

  logic [W-1:0] StreamData;
  logic         StreamValid;
  logic         StreamReady;

  modport master (
    output StreamData,
    output StreamValid,
    input  StreamReady
  );

  modport slave (
    input  StreamData,
    input  StreamValid,
    output StreamReady
  );

endinterface

// File: rtl/outword_stream_bridge_fifo.sv
// rtl/outword_stream_bridge_fifo.sv - synchronous FIFO with wrap-bit pointers and a registered head
module sync_fifo_r32i
  import outword_stream_bridge_pkg::*;
#(
  parameter int Width = 64,
  parameter int Depth = 8,
  localparam int PW = fifo_ptr_w(Depth),
  localparam int AW = PW - 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [PW-1:0]    level_o,
  output logic [Width-1:0] head_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [Width-1:0] head_q, head_d;
  logic [AW-1:0]    rnext;
  logic             do_push, do_pop;

  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    level_o = wptr_q - rptr_q;
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    rnext   = rptr_q[AW-1:0] + AW'(1);
    // The head register mirrors mem[rptr] one cycle ahead, so the next head
    // is taken from memory or straight from the incoming word.
    head_d  = head_q;
    if (do_pop) begin
      if (level_o > PW'(1)) head_d = mem_q[rnext];
      else if (do_push)     head_d = data_i;
    end else if (empty_o && do_push) begin
      head_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      head_q <= '0;
    end else if (flush_i) begin
      rptr_q <= wptr_q;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

  assign head_o = head_q;

endmodule

// File: rtl/outword_stream_bridge.sv
// rtl/outword_stream_bridge.sv - queues every change of {OutWord2, OutWord1} onto a valid/ready stream
module outword_stream_bridge
  import outword_stream_bridge_pkg::*;
#(
  parameter int dataW     = 32,
  parameter int FifoDepth = 8,
  parameter int DropCntW  = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [dataW-1:0]                  OutWord1,
  input  logic [dataW-1:0]                  OutWord2,
  input  logic                              Flush,
  input  logic                              ClearStatus,
  outword_stream_bridge_if.master           Stream,
  output logic [fifo_ptr_w(FifoDepth)-1:0]  Level,
  output logic                              Overflow,
  output logic [DropCntW-1:0]               DropCount
);

  localparam int PW = fifo_ptr_w(FifoDepth);

  logic [2*dataW-1:0] pair;
  logic [2*dataW-1:0] prev_q;
  logic               evt, push, drop, full, empty;
  logic               overflow_q, overflow_d;
  logic [DropCntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]      level;

  assign pair = {OutWord2, OutWord1};
  assign evt  = (pair != prev_q) && !reset;
  assign push = evt && !Flush;
  // When full the head is valid, so StreamReady alone decides whether a slot frees up.
  assign drop = push && full && !Stream.StreamReady;

  sync_fifo_r32i #(
    .Width (2*dataW),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .data_i  (pair),
    .pop_i   (Stream.StreamReady),
    .flush_i (Flush),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level),
    .head_o  (Stream.StreamData)
  );

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (ClearStatus)              drop_cnt_d = DropCntW'(1);
      else if (drop_cnt_q != '1)    drop_cnt_d = drop_cnt_q + DropCntW'(1);
    end else if (ClearStatus) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      prev_q     <= pair;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign Stream.StreamValid = !empty;
  assign Level              = level;
  assign Overflow           = overflow_q;
  assign DropCount          = drop_cnt_q;

endmodule

// File: doc/outword_stream_bridge.md
Name: outword_stream_bridge

Overview:
Downstream consumer of the processor's memory-mapped output ports (OutWord1, OutWord2).
- Detects every change of the {OutWord2, OutWord1} pair and queues the new pair in a small FIFO.
- Drains the FIFO through a valid/ready stream interface to a testbench monitor or external link, so the single-cycle core never stalls on output.
- Records overflow when the consumer falls behind.

Parameters:
dataW, 32, width of each output word
FifoDepth, 8, FIFO entries; power of 2, ≥2
DropCntW, 16, width of the dropped-event counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
OutWord1  in  dataW  processor output word 1
OutWord2  in  dataW  processor output word 2
StreamReady  in  1  consumer accepts head entry this cycle
Flush  in  1  discard all queued entries
ClearStatus  in  1  clear Overflow and DropCount
StreamData  out  2*dataW  head entry {OutWord2, OutWord1}
StreamValid  out  1  head entry valid
Level  out  $clog2(FifoDepth)+1  current occupancy
Overflow  out  1  sticky: at least one event dropped
DropCount  out  DropCntW  saturating count of dropped events

Behaviour:
- Reset values: PrevPair = 0; FIFO empty (read and write pointers 0); StreamValid = 0; StreamData = 0; Level = 0; Overflow = 0; DropCount = 0.
- Change detect:
  - Event = ({OutWord2, OutWord1} != PrevPair) && !reset.
  - PrevPair loads the current pair every non-reset cycle, including during Flush.
  - After reset, an all-zero pair generates no event.
- Push: on an event in cycle N, the pair is written at the clock edge ending cycle N.
  - If the FIFO was empty, StreamValid = 1 and StreamData = pair in cycle N+1. Latency is 1 cycle; there is no combinational bypass.
- Pop: occurs when StreamValid && StreamReady at a clock edge. The head advances and the next entry (if any) is presented the following cycle.
- Handshake rules:
  - StreamData is stable while StreamValid && !StreamReady.
  - StreamValid never deasserts without a pop, Flush or reset.
  - StreamReady is ignored when StreamValid = 0.
- Full boundary:
  - Push with Level == FifoDepth and no pop in the same cycle: the entry is dropped. Overflow sets to 1 and DropCount increments, saturating at all-ones.
  - Push and pop in the same cycle while full: both take effect; the entry is accepted and Level stays FifoDepth.
- Empty boundary: push and pop cannot coincide when empty, because StreamValid = 0.
- Pointers:
  - Pointers are $clog2(FifoDepth)+1 bits with wrap-around. Full when the MSBs differ and the remaining bits are equal. Empty when the pointers are equal.
  - Level = wptr − rptr (modulo).
- Flush (priority over push/pop):
  - Next cycle: pointers equal, Level = 0, StreamValid = 0.
  - An event in the flush cycle is discarded and not counted as a drop.
  - Overflow and DropCount are unaffected.
- ClearStatus: Overflow = 0 and DropCount = 0 next cycle. If a drop occurs in the same cycle, the drop wins: Overflow = 1 and DropCount = 1.
- Reset mid-operation: returns to the reset values next cycle, regardless of other inputs.
- Conceptual control states are EMPTY, PARTIAL and FULL, derived from the pointers; no separate state register.

Decomposition:
- Shared package: FIFO_PTR_W function (clog2(FifoDepth)+1) and the stream-entry struct type {word2, word1}. These are reused by future MMIO input bridges.
- Sub-module sync_fifo_r32i: parameterised synchronous FIFO with push, pop, flush, full, empty and level outputs, plus a registered head output.
- The top level holds only change detect, drop/overflow logic and status registers.

Test Plan:
- Reset, then hold OutWord1 = 0, OutWord2 = 0 for 10 cycles -> StreamValid = 0, Level = 0, DropCount = 0.
- Set OutWord1 = 0x0000_00AA at cycle 5 with StreamReady = 1 -> StreamValid = 1 at cycle 6 with StreamData = {0x0, 0xAA}, popped at cycle 6; Level returns to 0.
- StreamReady = 0, change OutWord2 on 10 consecutive cycles (values 1..10), FifoDepth = 8 -> Level = 8, Overflow = 1, DropCount = 2, and the head stays at {1, OutWord1} unchanged.
- Full FIFO, StreamReady = 1, new value 0x55 in the same cycle -> entry accepted, Level stays 8, DropCount unchanged; 0x55 appears 8 pops later.
- Level = 5, assert Flush together with an OutWord1 change -> next cycle Level = 0, StreamValid = 0, DropCount unchanged; a following change yields a single valid entry.
- ClearStatus and a drop in the same cycle, with DropCount = 3 -> Overflow = 1, DropCount = 1. Assert reset while Level = 4 -> all outputs return to their reset values next cycle.
